// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: register ids, stage flags, and
// the stall/flush/forward controls the controller drives back.
interface hazard_ctrl_if #(
  parameter int RF_ADD_W = 5,
  parameter int CNT_W    = 16
);
  logic [RF_ADD_W-1:0] i_id_src_0;
  logic [RF_ADD_W-1:0] i_id_src_1;
  logic [RF_ADD_W-1:0] i_ie_src_0;
  logic [RF_ADD_W-1:0] i_ie_src_1;
  logic [RF_ADD_W-1:0] i_ie_dst;
  logic                i_ie_rf_we;
  logic                i_ie_is_load;
  logic [RF_ADD_W-1:0] i_im_dst;
  logic                i_im_rf_we;
  logic [RF_ADD_W-1:0] i_iwb_dst;
  logic                i_iwb_rf_we;
  logic                i_nxt_pc_src;
  logic                i_ie_mc_op;
  logic                i_mc_done;
  logic [1:0]          o_forward_0;
  logic [1:0]          o_forward_1;
  logic                o_if_stall;
  logic                o_id_stall;
  logic                o_ie_stall;
  logic                o_id_flush;
  logic                o_ie_flush;
  logic                o_im_bubble;
  logic                o_mc_start;
  logic                o_mc_err;
  logic [CNT_W-1:0]    o_stall_cnt;
  logic [CNT_W-1:0]    o_flush_cnt;

  modport slave (
    input  i_id_src_0, i_id_src_1,
    input  i_ie_src_0, i_ie_src_1,
    input  i_ie_dst, i_ie_rf_we, i_ie_is_load,
    input  i_im_dst, i_im_rf_we,
    input  i_iwb_dst, i_iwb_rf_we,
    input  i_nxt_pc_src, i_ie_mc_op, i_mc_done,
    output o_forward_0, o_forward_1,
    output o_if_stall, o_id_stall, o_ie_stall,
    output o_id_flush, o_ie_flush, o_im_bubble,
    output o_mc_start, o_mc_err,
    output o_stall_cnt, o_flush_cnt
  );

  modport master (
    output i_id_src_0, i_id_src_1,
    output i_ie_src_0, i_ie_src_1,
    output i_ie_dst, i_ie_rf_we, i_ie_is_load,
    output i_im_dst, i_im_rf_we,
    output i_iwb_dst, i_iwb_rf_we,
    output i_nxt_pc_src, i_ie_mc_op, i_mc_done,
    input  o_forward_0, o_forward_1,
    input  o_if_stall, o_id_stall, o_ie_stall,
    input  o_id_flush, o_ie_flush, o_im_bubble,
    input  o_mc_start, o_mc_err,
    input  o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I core: forwarding, load-use
// stalls, branch flushes, multi-cycle IE op sequencing, perf counters.
module hazard_ctrl #(
    parameter int RF_ADD_W   = 5,
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input logic         i_clk,
    input logic         i_rstn,
    hazard_ctrl_if.slave bus
);

    localparam int TMR_W = $clog2(MC_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST =
        TMR_W'(MC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        RUN,
        MC_WAIT
    } state_e;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [1:0] im_hit;
    logic [1:0] wb_hit;
    logic [1:0] fwd_0, fwd_1;
    logic       load_use;
    logic       if_stall, id_stall, ie_stall;
    logic       id_flush, ie_flush, im_bubble;
    logic       mc_start;

    // x0 is hardwired zero, so a write to it must never be forwarded
    assign im_hit[0] = bus.i_im_rf_we
                     && (bus.i_im_dst != '0)
                     && (bus.i_im_dst == bus.i_ie_src_0);
    assign im_hit[1] = bus.i_im_rf_we
                     && (bus.i_im_dst != '0)
                     && (bus.i_im_dst == bus.i_ie_src_1);
    assign wb_hit[0] = bus.i_iwb_rf_we
                     && (bus.i_iwb_dst != '0)
                     && (bus.i_iwb_dst == bus.i_ie_src_0);
    assign wb_hit[1] = bus.i_iwb_rf_we
                     && (bus.i_iwb_dst != '0)
                     && (bus.i_iwb_dst == bus.i_ie_src_1);

    always_comb begin
        fwd_0 = 2'b00;
        fwd_1 = 2'b00;
        if (im_hit[0])      fwd_0 = 2'b01;
        else if (wb_hit[0]) fwd_0 = 2'b10;
        if (im_hit[1])      fwd_1 = 2'b01;
        else if (wb_hit[1]) fwd_1 = 2'b10;
    end

    assign load_use = bus.i_ie_is_load
                    && bus.i_ie_rf_we
                    && (bus.i_ie_dst != '0)
                    && ((bus.i_ie_dst == bus.i_id_src_0)
                     || (bus.i_ie_dst == bus.i_id_src_1));

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        err_d     = err_q;
        if_stall  = 1'b0;
        id_stall  = 1'b0;
        ie_stall  = 1'b0;
        id_flush  = 1'b0;
        ie_flush  = 1'b0;
        im_bubble = 1'b0;
        mc_start  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (bus.i_nxt_pc_src) begin
                    id_flush = 1'b1;
                    ie_flush = 1'b1;
                end else if (bus.i_ie_mc_op) begin
                    mc_start  = 1'b1;
                    if_stall  = 1'b1;
                    id_stall  = 1'b1;
                    ie_stall  = 1'b1;
                    im_bubble = 1'b1;
                    state_d   = MC_WAIT;
                    timer_d   = '0;
                end else if (load_use) begin
                    if_stall = 1'b1;
                    id_stall = 1'b1;
                    ie_flush = 1'b1;
                end
            end
            MC_WAIT: begin
                timer_d = timer_q + TMR_W'(1);
                // done wins over a coincident timeout
                if (bus.i_mc_done) begin
                    state_d = RUN;
                end else if (timer_q == TMR_LAST) begin
                    err_d   = 1'b1;
                    state_d = RUN;
                end else begin
                    if_stall  = 1'b1;
                    id_stall  = 1'b1;
                    ie_stall  = 1'b1;
                    im_bubble = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (if_stall && (stall_cnt_q != CNT_MAX))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (id_flush && (flush_cnt_q != CNT_MAX))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= RUN;
            timer_q     <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.o_forward_0 = fwd_0;
    assign bus.o_forward_1 = fwd_1;
    assign bus.o_if_stall  = if_stall;
    assign bus.o_id_stall  = id_stall;
    assign bus.o_ie_stall  = ie_stall;
    assign bus.o_id_flush  = id_flush;
    assign bus.o_ie_flush  = ie_flush;
    assign bus.o_im_bubble = im_bubble;
    assign bus.o_mc_start  = mc_start;
    assign bus.o_mc_err    = err_q;
    assign bus.o_stall_cnt = stall_cnt_q;
    assign bus.o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: per-cycle rule model plus directed literals,
// with a second instance using 4-bit counters for saturation.
module tb_hazard_ctrl;

    localparam int TO   = 64;
    localparam int MAX16 = 65535;
    localparam int MAX4  = 15;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.RF_ADD_W(5), .CNT_W(16)) bus ();
    hazard_ctrl_if #(.RF_ADD_W(5), .CNT_W(4))  bus4 ();

    assign bus4.i_id_src_0   = bus.i_id_src_0;
    assign bus4.i_id_src_1   = bus.i_id_src_1;
    assign bus4.i_ie_src_0   = bus.i_ie_src_0;
    assign bus4.i_ie_src_1   = bus.i_ie_src_1;
    assign bus4.i_ie_dst     = bus.i_ie_dst;
    assign bus4.i_ie_rf_we   = bus.i_ie_rf_we;
    assign bus4.i_ie_is_load = bus.i_ie_is_load;
    assign bus4.i_im_dst     = bus.i_im_dst;
    assign bus4.i_im_rf_we   = bus.i_im_rf_we;
    assign bus4.i_iwb_dst    = bus.i_iwb_dst;
    assign bus4.i_iwb_rf_we  = bus.i_iwb_rf_we;
    assign bus4.i_nxt_pc_src = bus.i_nxt_pc_src;
    assign bus4.i_ie_mc_op   = bus.i_ie_mc_op;
    assign bus4.i_mc_done    = bus.i_mc_done;

    hazard_ctrl #(
        .RF_ADD_W(5), .MC_TIMEOUT(TO), .CNT_W(16)
    ) u_dut (
        .i_clk(clk), .i_rstn(rstn), .bus(bus)
    );

    hazard_ctrl #(
        .RF_ADD_W(5), .MC_TIMEOUT(TO), .CNT_W(4)
    ) u_dut4 (
        .i_clk(clk), .i_rstn(rstn), .bus(bus4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // model: busy flag, cycles since the start pulse, sticky error, counts
    bit m_busy = 0;
    int m_n    = 0;
    bit m_err  = 0;
    int m_s    = 0;
    int m_f    = 0;
    int m_s4   = 0;
    int m_f4   = 0;

    int e_f0, e_f1;
    bit e_if, e_id, e_ie, e_idf, e_ief, e_bub, e_start;
    bit lu;

    function automatic int fwd(logic [4:0] src);
        if (bus.i_im_rf_we && bus.i_im_dst != 0
            && bus.i_im_dst == src) return 1;
        if (bus.i_iwb_rf_we && bus.i_iwb_dst != 0
            && bus.i_iwb_dst == src) return 2;
        return 0;
    endfunction

    always_comb begin
        e_f0 = fwd(bus.i_ie_src_0);
        e_f1 = fwd(bus.i_ie_src_1);
        e_if = 0; e_id = 0; e_ie = 0;
        e_idf = 0; e_ief = 0; e_bub = 0; e_start = 0;
        lu = bus.i_ie_is_load && bus.i_ie_rf_we
          && bus.i_ie_dst != 0
          && (bus.i_ie_dst == bus.i_id_src_0
           || bus.i_ie_dst == bus.i_id_src_1);
        if (!m_busy) begin
            if (bus.i_nxt_pc_src) begin
                e_idf = 1; e_ief = 1;
            end else if (bus.i_ie_mc_op) begin
                e_start = 1; e_if = 1; e_id = 1;
                e_ie = 1; e_bub = 1;
            end else if (lu) begin
                e_if = 1; e_id = 1; e_ief = 1;
            end
        end else if (!bus.i_mc_done && m_n != TO) begin
            e_if = 1; e_id = 1; e_ie = 1; e_bub = 1;
        end
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_busy <= 0; m_n <= 0; m_err <= 0;
            m_s <= 0; m_f <= 0; m_s4 <= 0; m_f4 <= 0;
        end else begin
            if (e_if && m_s  < MAX16) m_s  <= m_s + 1;
            if (e_if && m_s4 < MAX4)  m_s4 <= m_s4 + 1;
            if (e_idf && m_f  < MAX16) m_f  <= m_f + 1;
            if (e_idf && m_f4 < MAX4)  m_f4 <= m_f4 + 1;
            if (!m_busy) begin
                if (e_start) begin
                    m_busy <= 1; m_n <= 1;
                end
            end else if (bus.i_mc_done) begin
                m_busy <= 0;
            end else if (m_n == TO) begin
                m_busy <= 0; m_err <= 1;
            end else begin
                m_n <= m_n + 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("fwd0", int'(bus.o_forward_0), e_f0);
        chk("fwd1", int'(bus.o_forward_1), e_f1);
        chk("if_stall", int'(bus.o_if_stall), int'(e_if));
        chk("id_stall", int'(bus.o_id_stall), int'(e_id));
        chk("ie_stall", int'(bus.o_ie_stall), int'(e_ie));
        chk("id_flush", int'(bus.o_id_flush), int'(e_idf));
        chk("ie_flush", int'(bus.o_ie_flush), int'(e_ief));
        chk("im_bubble", int'(bus.o_im_bubble), int'(e_bub));
        chk("mc_start", int'(bus.o_mc_start), int'(e_start));
        chk("mc_err", int'(bus.o_mc_err), int'(m_err));
        chk("stall_cnt", int'(bus.o_stall_cnt), m_s);
        chk("flush_cnt", int'(bus.o_flush_cnt), m_f);
        chk("stall_cnt4", int'(bus4.o_stall_cnt), m_s4);
        chk("flush_cnt4", int'(bus4.o_flush_cnt), m_f4);
        chk("if_stall4", int'(bus4.o_if_stall), int'(e_if));
        chk("mc_err4", int'(bus4.o_mc_err), int'(m_err));
    end

    task automatic clr();
        bus.i_id_src_0   = 5'd0;
        bus.i_id_src_1   = 5'd0;
        bus.i_ie_src_0   = 5'd0;
        bus.i_ie_src_1   = 5'd0;
        bus.i_ie_dst     = 5'd0;
        bus.i_ie_rf_we   = 1'b0;
        bus.i_ie_is_load = 1'b0;
        bus.i_im_dst     = 5'd0;
        bus.i_im_rf_we   = 1'b0;
        bus.i_iwb_dst    = 5'd0;
        bus.i_iwb_rf_we  = 1'b0;
        bus.i_nxt_pc_src = 1'b0;
        bus.i_ie_mc_op   = 1'b0;
        bus.i_mc_done    = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu();
        bus.i_ie_is_load = 1'b1;
        bus.i_ie_rf_we   = 1'b1;
        bus.i_ie_dst     = 5'd7;
        bus.i_id_src_1   = 5'd7;
    endtask

    int n_start;
    int n_stall;

    initial begin
        clr();
        rstn = 1'b0;
        repeat (3) cyc();
        chk("rst_stall_cnt", int'(bus.o_stall_cnt), 0);
        chk("rst_mc_err", int'(bus.o_mc_err), 0);
        chk("rst_if_stall", int'(bus.o_if_stall), 0);
        rstn = 1'b1;
        cyc();

        // forwarding priority and x0 exclusion
        bus.i_im_dst = 5'd5;  bus.i_im_rf_we = 1'b1;
        bus.i_iwb_dst = 5'd5; bus.i_iwb_rf_we = 1'b1;
        bus.i_ie_src_0 = 5'd5;
        #1 chk("t1_im_wins", int'(bus.o_forward_0), 1);
        bus.i_im_dst = 5'd0;
        #1 chk("t1_wb_x0im", int'(bus.o_forward_0), 2);
        bus.i_ie_src_0 = 5'd6;
        #1 chk("t1_none", int'(bus.o_forward_0), 0);
        bus.i_ie_src_1 = 5'd5;
        #1 chk("t1_wb_op1", int'(bus.o_forward_1), 2);
        cyc();
        clr();

        // load-use: one bubble
        set_lu();
        #2;
        chk("t2_if_stall", int'(bus.o_if_stall), 1);
        chk("t2_id_stall", int'(bus.o_id_stall), 1);
        chk("t2_ie_flush", int'(bus.o_ie_flush), 1);
        chk("t2_ie_stall", int'(bus.o_ie_stall), 0);
        cyc();
        clr();
        #2;
        chk("t2_after", int'(bus.o_if_stall), 0);
        chk("t2_cnt", int'(bus.o_stall_cnt), 1);

        // branch beats load-use
        set_lu();
        bus.i_nxt_pc_src = 1'b1;
        #2;
        chk("t3_id_flush", int'(bus.o_id_flush), 1);
        chk("t3_ie_flush", int'(bus.o_ie_flush), 1);
        chk("t3_if_stall", int'(bus.o_if_stall), 0);
        cyc();
        clr();
        #2;
        chk("t3_flush_cnt", int'(bus.o_flush_cnt), 1);
        chk("t3_stall_cnt", int'(bus.o_stall_cnt), 1);

        // multi-cycle op, done on cycle 33
        n_start = 0;
        n_stall = 0;
        bus.i_ie_mc_op = 1'b1;
        for (int i = 0; i <= 33; i++) begin
            bus.i_mc_done = (i == 33);
            #2;
            if (bus.o_mc_start) n_start++;
            if (i < 33 && bus.o_if_stall && bus.o_ie_stall) n_stall++;
            if (i == 33)
                chk("t4_done_stall", int'(bus.o_if_stall), 0);
            cyc();
        end
        chk("t4_starts", n_start, 1);
        chk("t4_stalls", n_stall, 33);
        bus.i_mc_done = 1'b0;
        #2 chk("t4_b2b_start", int'(bus.o_mc_start), 1);
        cyc();
        bus.i_mc_done = 1'b1;
        #2 chk("t4_b2b_done", int'(bus.o_if_stall), 0);
        cyc();
        clr();
        #2;
        chk("t4_idle_start", int'(bus.o_mc_start), 0);
        chk("t4_stall_cnt", int'(bus.o_stall_cnt), 35);
        chk("t4_stall_cnt4", int'(bus4.o_stall_cnt), 15);

        // timeout: stalls drop on cycle 64, error sticky
        n_stall = 0;
        bus.i_ie_mc_op = 1'b1;
        for (int i = 0; i <= TO; i++) begin
            #2;
            if (i < TO && bus.o_if_stall) n_stall++;
            if (i == TO)
                chk("t5_drop", int'(bus.o_if_stall), 0);
            cyc();
        end
        chk("t5_stalls", n_stall, TO);
        clr();
        #2 chk("t5_err", int'(bus.o_mc_err), 1);
        repeat (5) cyc();
        chk("t5_err_sticky", int'(bus.o_mc_err), 1);
        rstn = 1'b0;
        #1 chk("t5_err_rst", int'(bus.o_mc_err), 0);
        cyc();
        rstn = 1'b1;
        cyc();

        // async reset in the middle of MC_WAIT
        bus.i_ie_mc_op = 1'b1;
        repeat (6) cyc();
        #2 chk("t6_pre_stall", int'(bus.o_if_stall), 1);
        rstn = 1'b0;
        bus.i_ie_mc_op = 1'b0;
        #1;
        chk("t6_if_stall", int'(bus.o_if_stall), 0);
        chk("t6_bubble", int'(bus.o_im_bubble), 0);
        chk("t6_cnt", int'(bus.o_stall_cnt), 0);
        repeat (2) cyc();
        rstn = 1'b1;
        cyc();
        #2 chk("t6_no_start", int'(bus.o_mc_start), 0);

        // 20 stall cycles saturate the 4-bit counter
        set_lu();
        repeat (20) cyc();
        clr();
        #2;
        chk("t6_sat4", int'(bus4.o_stall_cnt), 15);
        chk("t6_cnt16", int'(bus.o_stall_cnt), 20);
        repeat (2) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
